// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Memory-access stage between execute and a word-organised, big-endian data
// memory. Accepts one load/store at a time and turns it into word accesses:
// byte/halfword stores become read-modify-write, byte/halfword loads are
// extracted and sign- or zero-extended. Misaligned or reserved-size requests
// are rejected without touching memory. Each request ends with a one-cycle
// response pulse.
//
// Ports
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_req_valid           request present (sampled only while idle)
//   o_req_ready           high only while idle and out of reset
//   i_req_write           1 = store, 0 = load
//   i_req_size            00 byte, 01 half, 10 word, 11 reserved
//   i_req_unsigned        loads: 1 = zero-extend, 0 = sign-extend
//   i_req_addr            byte address
//   i_req_wdata           store data, right-justified for byte/half
//   o_resp_valid          one-cycle completion pulse
//   o_resp_rdata          load result, 0 for stores and rejected requests
//   o_resp_misaligned     request was rejected (valid with o_resp_valid)
//   o_dmem_address        word-aligned memory address, parked at all-ones
//   o_dmem_data_in        memory write data
//   o_dmem_mem_write      memory write strobe (memory commits on negedge)
//   o_dmem_mem_read       memory read enable
//   i_dmem_data_out       memory read data, byte offset 0 = bits 31:24
// ---------------------------------------------------------------------------
module load_store_unit (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_misaligned,
    output logic [31:0] o_dmem_address,
    output logic [31:0] o_dmem_data_in,
    output logic        o_dmem_mem_write,
    output logic        o_dmem_mem_read,
    input  logic [31:0] i_dmem_data_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // The memory only refreshes its read data when the address changes, so
    // the bus idles at an address that no aligned access can ever use.
    localparam logic [31:0] PARK_ADDR = 32'hFFFF_FFFF;

    state_t      r_state;
    state_t      w_next;
    logic        w_misaligned;
    logic        w_accept;

    // Captured request
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    // Registered outputs
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_misaligned;
    logic [31:0] r_dmem_address;
    logic [31:0] r_dmem_data_in;
    logic        r_dmem_mem_write;
    logic        r_dmem_mem_read;

    // Pull a byte or halfword out of a big-endian word and extend it.
    function automatic logic [31:0] f_extract(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [1:0]  size,
                                              input logic        uns);
        logic [7:0]  v_b;
        logic [15:0] v_h;
        logic [31:0] v_res;
        case (off)
            2'd0:    v_b = word[31:24];
            2'd1:    v_b = word[23:16];
            2'd2:    v_b = word[15:8];
            default: v_b = word[7:0];
        endcase
        v_h = off[1] ? word[15:0] : word[31:16];
        case (size)
            2'b00:   v_res = uns ? {24'd0, v_b} : {{24{v_b[7]}}, v_b};
            2'b01:   v_res = uns ? {16'd0, v_h} : {{16{v_h[15]}}, v_h};
            default: v_res = word;
        endcase
        return v_res;
    endfunction

    // Replace the addressed byte/halfword lane of the old word with new data.
    function automatic logic [31:0] f_merge(input logic [31:0] word,
                                            input logic [1:0]  off,
                                            input logic [1:0]  size,
                                            input logic [31:0] wdata);
        logic [31:0] v_res;
        v_res = word;
        case (size)
            2'b00: begin
                case (off)
                    2'd0:    v_res[31:24] = wdata[7:0];
                    2'd1:    v_res[23:16] = wdata[7:0];
                    2'd2:    v_res[15:8]  = wdata[7:0];
                    default: v_res[7:0]   = wdata[7:0];
                endcase
            end
            2'b01: begin
                if (off[1]) v_res[15:0]  = wdata[15:0];
                else        v_res[31:16] = wdata[15:0];
            end
            default: v_res = wdata;
        endcase
        return v_res;
    endfunction

    assign w_accept     = (r_state == S_IDLE) && i_req_valid;
    assign w_misaligned = (i_req_size == 2'b11) ||
                          ((i_req_size == 2'b01) && i_req_addr[0]) ||
                          ((i_req_size == 2'b10) && (i_req_addr[1:0] != 2'b00));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_req_valid) begin
                    if (w_misaligned)                w_next = S_RESP;
                    else if (!i_req_write)           w_next = S_RD;
                    else if (i_req_size == 2'b10)    w_next = S_WR;
                    else                             w_next = S_RD;
                end
            end
            S_RD:    w_next = r_write ? S_WR : S_RESP;
            S_WR:    w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Request capture: data only, no reset needed.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_write    <= i_req_write;
            r_size     <= i_req_size;
            r_unsigned <= i_req_unsigned;
            r_addr     <= i_req_addr;
            r_wdata    <= i_req_wdata;
        end
    end

    // State and outputs. Outputs are set on the edge that enters the state
    // they belong to, so they line up with the state they describe.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state           <= S_IDLE;
            r_resp_valid      <= 1'b0;
            r_resp_rdata      <= 32'd0;
            r_resp_misaligned <= 1'b0;
            r_dmem_address    <= PARK_ADDR;
            r_dmem_data_in    <= 32'd0;
            r_dmem_mem_write  <= 1'b0;
            r_dmem_mem_read   <= 1'b0;
        end else begin
            r_state           <= w_next;
            r_resp_valid      <= 1'b0;
            r_resp_rdata      <= 32'd0;
            r_resp_misaligned <= 1'b0;
            r_dmem_address    <= PARK_ADDR;
            r_dmem_data_in    <= 32'd0;
            r_dmem_mem_write  <= 1'b0;
            r_dmem_mem_read   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        case (w_next)
                            S_RESP: begin
                                r_resp_valid      <= 1'b1;
                                r_resp_misaligned <= 1'b1;
                            end
                            S_RD: begin
                                r_dmem_mem_read <= 1'b1;
                                r_dmem_address  <= {i_req_addr[31:2], 2'b00};
                            end
                            S_WR: begin
                                r_dmem_mem_write <= 1'b1;
                                r_dmem_address   <= {i_req_addr[31:2], 2'b00};
                                r_dmem_data_in   <= i_req_wdata;
                            end
                            default: ;
                        endcase
                    end
                end
                S_RD: begin
                    // Read data is consumed directly at the end of the RD cycle.
                    if (r_write) begin
                        r_dmem_mem_write <= 1'b1;
                        r_dmem_address   <= {r_addr[31:2], 2'b00};
                        r_dmem_data_in   <= f_merge(i_dmem_data_out, r_addr[1:0],
                                                    r_size, r_wdata);
                    end else begin
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= f_extract(i_dmem_data_out, r_addr[1:0],
                                                  r_size, r_unsigned);
                    end
                end
                S_WR: begin
                    r_resp_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_req_ready       = i_rst_n && (r_state == S_IDLE);
    assign o_resp_valid      = r_resp_valid;
    assign o_resp_rdata      = r_resp_rdata;
    assign o_resp_misaligned = r_resp_misaligned;
    assign o_dmem_address    = r_dmem_address;
    assign o_dmem_data_in    = r_dmem_data_in;
    assign o_dmem_mem_write  = r_dmem_mem_write;
    assign o_dmem_mem_read   = r_dmem_mem_read;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed bench for load_store_unit with a small big-endian data memory
// model. Expected responses are queued when a request is issued and checked
// when the response pulse appears, together with its latency and the dmem
// strobe activity of each cycle.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic [31:0] dmem_address;
    logic [31:0] dmem_data_in;
    logic        dmem_mem_write;
    logic        dmem_mem_read;
    logic [31:0] dmem_data_out;

    load_store_unit dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_req_valid       (req_valid),
        .o_req_ready       (req_ready),
        .i_req_write       (req_write),
        .i_req_size        (req_size),
        .i_req_unsigned    (req_unsigned),
        .i_req_addr        (req_addr),
        .i_req_wdata       (req_wdata),
        .o_resp_valid      (resp_valid),
        .o_resp_rdata      (resp_rdata),
        .o_resp_misaligned (resp_misaligned),
        .o_dmem_address    (dmem_address),
        .o_dmem_data_in    (dmem_data_in),
        .o_dmem_mem_write  (dmem_mem_write),
        .o_dmem_mem_read   (dmem_mem_read),
        .i_dmem_data_out   (dmem_data_out)
    );

    always #5 clk = ~clk;

    // Memory model: 256 words, commits writes on negedge, refreshes read
    // data only when the address changes.
    logic [31:0] mem [0:255];
    logic        pre_en = 1'b0;
    logic [31:0] pre_addr = 32'd0;
    logic [31:0] pre_data = 32'd0;

    always @(negedge clk) begin
        if (pre_en)              mem[pre_addr[9:2]]     <= pre_data;
        else if (dmem_mem_write) mem[dmem_address[9:2]] <= dmem_data_in;
    end

    always @(dmem_address) dmem_data_out = mem[dmem_address[9:2]];

    int wr_cnt = 0;
    int rd_cnt = 0;
    always @(posedge clk) begin
        if (dmem_mem_write) wr_cnt <= wr_cnt + 1;
        if (dmem_mem_read)  rd_cnt <= rd_cnt + 1;
    end

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    int n_total = 0;
    int n_pass  = 0;

    logic        obs_rd   [1:6];
    logic        obs_wr   [1:6];
    logic [31:0] obs_addr [1:6];
    logic [31:0] obs_din  [1:6];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pre_addr = a;
        pre_data = d;
        pre_en   = 1'b1;
        @(negedge clk);
        #1;
        pre_en   = 1'b0;
        tick();
    endtask

    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_mis,
                          input int exp_lat, input string tag);
        int   wait_n;
        bit   seen;
        exp_t e;
        wait_n = 0;
        seen   = 1'b0;
        while (!req_ready && wait_n < 10) begin
            tick();
            wait_n++;
        end
        chk({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        e.rdata = exp_rd;
        e.mis   = exp_mis;
        e.lat   = exp_lat;
        sb_q.push_back(e);
        tick();
        // Junk on the request bus must be ignored while busy.
        req_valid    = 1'b1;
        req_write    = ~wr;
        req_size     = 2'b11;
        req_addr     = 32'h0000_0FFF;
        req_wdata    = 32'h5A5A_5A5A;
        for (int k = 1; k <= 6; k++) begin
            obs_rd[k]   = dmem_mem_read;
            obs_wr[k]   = dmem_mem_write;
            obs_addr[k] = dmem_address;
            obs_din[k]  = dmem_data_in;
            if (resp_valid) begin
                req_valid = 1'b0;
                e = sb_q.pop_front();
                chk({tag, ".rdata"}, resp_rdata, e.rdata);
                chk({tag, ".mis"}, {31'd0, resp_misaligned}, {31'd0, e.mis});
                chk({tag, ".lat"}, k, e.lat);
                seen = 1'b1;
                break;
            end
            tick();
        end
        req_valid = 1'b0;
        if (!seen) begin
            chk({tag, ".timeout"}, 32'd0, 32'd1);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end
    endtask

    initial begin
        int wc0;
        int rc0;
        bit any_resp;

        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;

        // Reset state
        tick();
        tick();
        chk("rst.ready", {31'd0, req_ready}, 32'd0);
        chk("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst.mis", {31'd0, resp_misaligned}, 32'd0);
        chk("rst.rdata", resp_rdata, 32'd0);
        chk("rst.addr", dmem_address, 32'hFFFF_FFFF);
        chk("rst.din", dmem_data_in, 32'd0);
        chk("rst.strobes", {30'd0, dmem_mem_read, dmem_mem_write}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst.ready_after", {31'd0, req_ready}, 32'd1);

        // Word store then word load
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'd0, 1'b0, 2, "sw10");
        chk("sw10.wr1", {31'd0, obs_wr[1]}, 32'd1);
        chk("sw10.rd1", {31'd0, obs_rd[1]}, 32'd0);
        chk("sw10.addr1", obs_addr[1], 32'h10);
        chk("sw10.din1", obs_din[1], 32'hDEAD_BEEF);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0, 2, "lw10");
        chk("lw10.rd1", {31'd0, obs_rd[1]}, 32'd1);
        chk("lw10.addr1", obs_addr[1], 32'h10);

        // Byte read-modify-write
        preload(32'h20, 32'h1122_3344);
        do_req(1'b1, 2'b00, 1'b0, 32'h22, 32'h0000_00AA, 32'd0, 1'b0, 3, "sb22");
        chk("sb22.rd1", {31'd0, obs_rd[1]}, 32'd1);
        chk("sb22.addr1", obs_addr[1], 32'h20);
        chk("sb22.wr2", {31'd0, obs_wr[2]}, 32'd1);
        chk("sb22.din2", obs_din[2], 32'h1122_AA44);
        do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 32'h1122_AA44, 1'b0, 2, "lw20a");

        // Halfword stores into both halves, upper wdata bits must be dropped
        do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF_BEEF, 32'd0, 1'b0, 3, "sh22");
        chk("sh22.din2", obs_din[2], 32'h1122_BEEF);
        do_req(1'b1, 2'b01, 1'b0, 32'h20, 32'hABCD_1234, 32'd0, 1'b0, 3, "sh20");
        chk("sh20.din2", obs_din[2], 32'h1234_BEEF);
        do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 32'h1234_BEEF, 1'b0, 2, "lw20b");

        // Sign/zero extension
        preload(32'h30, 32'h80FF_7F01);
        do_req(1'b0, 2'b00, 1'b0, 32'h30, 32'd0, 32'hFFFF_FF80, 1'b0, 2, "lb30");
        do_req(1'b0, 2'b00, 1'b1, 32'h30, 32'd0, 32'h0000_0080, 1'b0, 2, "lbu30");
        do_req(1'b0, 2'b01, 1'b0, 32'h32, 32'd0, 32'h0000_7F01, 1'b0, 2, "lh32");
        do_req(1'b0, 2'b01, 1'b0, 32'h30, 32'd0, 32'hFFFF_80FF, 1'b0, 2, "lh30");
        do_req(1'b0, 2'b01, 1'b1, 32'h30, 32'd0, 32'h0000_80FF, 1'b0, 2, "lhu30");
        do_req(1'b0, 2'b00, 1'b0, 32'h31, 32'd0, 32'hFFFF_FFFF, 1'b0, 2, "lb31");
        do_req(1'b0, 2'b00, 1'b1, 32'h32, 32'd0, 32'h0000_007F, 1'b0, 2, "lbu32");
        do_req(1'b0, 2'b00, 1'b0, 32'h33, 32'd0, 32'h0000_0001, 1'b0, 2, "lb33");

        // Misaligned / reserved: rejected in cycle 1, no strobes
        wc0 = wr_cnt;
        rc0 = rd_cnt;
        do_req(1'b0, 2'b10, 1'b0, 32'h41, 32'd0, 32'd0, 1'b1, 1, "lw41");
        do_req(1'b0, 2'b01, 1'b0, 32'h43, 32'd0, 32'd0, 1'b1, 1, "lh43");
        do_req(1'b0, 2'b11, 1'b0, 32'h40, 32'd0, 32'd0, 1'b1, 1, "sz11");
        do_req(1'b1, 2'b10, 1'b0, 32'h42, 32'h1357_9BDF, 32'd0, 1'b1, 1, "sw42");
        tick();
        chk("mis.wr_cnt", wr_cnt, wc0);
        chk("mis.rd_cnt", rd_cnt, rc0);

        // Back-to-back same address with the parked address in between
        preload(32'h50, 32'h0102_0304);
        do_req(1'b1, 2'b00, 1'b0, 32'h50, 32'h0000_0055, 32'd0, 1'b0, 3, "sb50");
        chk("sb50.park", obs_addr[3], 32'hFFFF_FFFF);
        do_req(1'b0, 2'b10, 1'b0, 32'h50, 32'd0, 32'h5502_0304, 1'b0, 2, "lw50");

        // Reset during the RD cycle of a byte store
        preload(32'h60, 32'hCAFE_F00D);
        chk("rrst.ready0", {31'd0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_write    = 1'b1;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h61;
        req_wdata    = 32'h0000_0099;
        tick();
        req_valid = 1'b0;
        chk("rrst.rd1", {31'd0, dmem_mem_read}, 32'd1);
        wc0 = wr_cnt;
        rst_n = 1'b0;
        tick();
        chk("rrst.wr", {31'd0, dmem_mem_write}, 32'd0);
        chk("rrst.rd", {31'd0, dmem_mem_read}, 32'd0);
        chk("rrst.addr", dmem_address, 32'hFFFF_FFFF);
        chk("rrst.din", dmem_data_in, 32'd0);
        chk("rrst.ready", {31'd0, req_ready}, 32'd0);
        any_resp = resp_valid;
        for (int i = 0; i < 3; i++) begin
            tick();
            any_resp = any_resp | resp_valid;
        end
        chk("rrst.no_resp", {31'd0, any_resp}, 32'd0);
        rst_n = 1'b1;
        tick();
        any_resp = resp_valid;
        tick();
        any_resp = any_resp | resp_valid;
        chk("rrst.no_resp_after", {31'd0, any_resp}, 32'd0);
        chk("rrst.wr_cnt", wr_cnt, wc0);
        do_req(1'b0, 2'b10, 1'b0, 32'h60, 32'd0, 32'hCAFE_F00D, 1'b0, 2, "lw60");
        chk("sb.empty", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
